x_delay_line: RTL

- Parametrised successor to the two-stage x(n) delay register in the CeNN cell datapath.
- Delays CHANNELS parallel state samples x(n) through a DEPTH-stage shift register. A runtime-selectable tap aligns them with the mask/template pipeline.
- Produces a warm-up activation flag (active_delay) and per-tap data validity (x_valid).
- Sits between the cell state-update output and the template-multiply stage.

---
 rtl/x_delay_line.sv | 116 +++++++++++
 1 files changed

// File: rtl/x_delay_line.sv
// Multi-channel x(n) delay line for the CeNN cell datapath: DEPTH-stage shift
// register per channel, saturating tap mux, per-stage validity and warm-up flag.

module x_delay_lane #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int TW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift,
    input  logic             i_clear,
    input  logic [TW-1:0]    i_tap,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else if (i_clear) begin
            r_stage <= '0;
        end else if (i_shift) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    // i_tap arrives already saturated to DEPTH-1
    always_comb begin
        o_q = r_stage[0];
        for (int i = 1; i < DEPTH; i++)
            if (i_tap == TW'(i)) o_q = r_stage[i];
    end
endmodule

module x_delay_line #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter int CHANNELS = 1,
    parameter int WARMUP   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_ready,
    input  logic                      flush,
    input  logic [$clog2(DEPTH):0]    tap_sel,
    input  logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS*WIDTH-1:0] x_n,
    output logic                      x_valid,
    output logic                      active_delay,
    output logic [3:0]                warm_count
);
    localparam int TW = $clog2(DEPTH) + 1;

    logic             w_shift;
    logic [TW-1:0]    w_tap;
    logic [DEPTH-1:0] r_valid;
    logic [3:0]       r_warm;
    logic             r_active;

    assign w_shift = read_ready & ~flush;
    assign w_tap   = (tap_sel > TW'(DEPTH-1)) ? TW'(DEPTH-1) : tap_sel;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        x_delay_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TW(TW)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_shift (w_shift),
            .i_clear (flush),
            .i_tap   (w_tap),
            .i_d     (out[c*WIDTH +: WIDTH]),
            .o_q     (x_n[c*WIDTH +: WIDTH])
        );
    end

    // Validity is shared by all channels since they always shift together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (read_ready) begin
            r_valid[0] <= 1'b1;
            for (int i = 1; i < DEPTH; i++) r_valid[i] <= r_valid[i-1];
        end
    end

    always_comb begin
        x_valid = r_valid[0];
        for (int i = 1; i < DEPTH; i++)
            if (w_tap == TW'(i)) x_valid = r_valid[i];
    end

    // Counter saturates at WARMUP; the flag rises on the following enabled edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_warm   <= 4'd0;
            r_active <= 1'b0;
        end else if (flush) begin
            r_warm   <= 4'd0;
            r_active <= 1'b0;
        end else if (read_ready) begin
            if (r_warm < 4'(WARMUP)) begin
                r_warm   <= r_warm + 4'd1;
                r_active <= 1'b0;
            end else begin
                r_active <= 1'b1;
            end
        end
    end

    assign warm_count   = r_warm;
    assign active_delay = r_active;
endmodule
